sdram_port_arbiter: RTL and testbench

//  Two-channel arbiter that shares one SDRAM burst controller between two dcfifo_ctrl

---
 rtl/sdram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-channel burst arbiter in front of one SDRAM controller core
//
// Shares one burst controller between two FIFO channels. Writes beat reads;
// within a class the channel that did not go last wins. One burst at a time:
// IDLE -> REQ -> BURST -> RELEASE -> IDLE.
//
// Ports
//   clk_ref, rst_n                     clock, async active-low reset
//   chN_wr_req / chN_rd_req            channel burst requests (level)
//   chN_wraddr / chN_rdaddr            channel burst addresses
//   chN_wr_length / chN_rd_length      channel burst lengths
//   chN_din                            channel write data
//   chN_wr_ack / chN_rd_ack            acks steered to the selected channel only
//   sdram_wr_req / sdram_rd_req        registered requests to the core
//   sdram_wraddr/rdaddr/lengths/din    fields of the selected channel
//   sdram_wr_ack / sdram_rd_ack        core acks, high for the whole burst
//   grant_ch, busy, timeout_err        selected channel, not-idle, sticky ack timeout
module sdram_port_arbiter #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        ch0_wr_req,
    input  logic        ch0_rd_req,
    input  logic [21:0] ch0_wraddr,
    input  logic [21:0] ch0_rdaddr,
    input  logic [8:0]  ch0_wr_length,
    input  logic [8:0]  ch0_rd_length,
    input  logic [15:0] ch0_din,
    output logic        ch0_wr_ack,
    output logic        ch0_rd_ack,
    input  logic        ch1_wr_req,
    input  logic        ch1_rd_req,
    input  logic [21:0] ch1_wraddr,
    input  logic [21:0] ch1_rdaddr,
    input  logic [8:0]  ch1_wr_length,
    input  logic [8:0]  ch1_rd_length,
    input  logic [15:0] ch1_din,
    output logic        ch1_wr_ack,
    output logic        ch1_rd_ack,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    output logic [21:0] sdram_wraddr,
    output logic [21:0] sdram_rdaddr,
    output logic [8:0]  sdram_wr_length,
    output logic [8:0]  sdram_rd_length,
    output logic [15:0] sdram_din,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    output logic        grant_ch,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, BURST, RELEASE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);

    state_t          state;
    logic            sel_ch;
    logic            dir_rd;
    logic            last_wr_ch;
    logic            last_rd_ch;
    logic [TO_W-1:0] to_cnt;

    logic wr_pick;
    logic rd_pick;
    logic sel_req;
    logic match_ack;

    // Round-robin: the channel that was not served last wins if it is asking.
    always_comb begin
        wr_pick = last_wr_ch;
        rd_pick = last_rd_ch;
        if (last_wr_ch ? ch0_wr_req : ch1_wr_req)
            wr_pick = ~last_wr_ch;
        if (last_rd_ch ? ch0_rd_req : ch1_rd_req)
            rd_pick = ~last_rd_ch;
    end

    // Request level and core ack for the latched channel/direction.
    always_comb begin
        sel_req   = 1'b0;
        match_ack = dir_rd ? sdram_rd_ack : sdram_wr_ack;
        case ({dir_rd, sel_ch})
            2'b00:   sel_req = ch0_wr_req;
            2'b01:   sel_req = ch1_wr_req;
            2'b10:   sel_req = ch0_rd_req;
            default: sel_req = ch1_rd_req;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel_ch       <= 1'b0;
            dir_rd       <= 1'b0;
            last_wr_ch   <= 1'b1;
            last_rd_ch   <= 1'b1;
            to_cnt       <= '0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (ch0_wr_req || ch1_wr_req) begin
                        sel_ch       <= wr_pick;
                        dir_rd       <= 1'b0;
                        sdram_wr_req <= 1'b1;
                        busy         <= 1'b1;
                        state        <= REQ;
                    end else if (ch0_rd_req || ch1_rd_req) begin
                        sel_ch       <= rd_pick;
                        dir_rd       <= 1'b1;
                        sdram_rd_req <= 1'b1;
                        busy         <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    // Ack wins over a same-cycle withdrawal or timeout.
                    if (match_ack) begin
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        state        <= BURST;
                    end else if (!sel_req) begin
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (ACK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        busy         <= 1'b0;
                        timeout_err  <= 1'b1;
                        if (dir_rd) last_rd_ch <= sel_ch;
                        else        last_wr_ch <= sel_ch;
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                BURST: begin
                    if (!match_ack)
                        state <= RELEASE;
                end
                default: begin
                    if (dir_rd) last_rd_ch <= sel_ch;
                    else        last_wr_ch <= sel_ch;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign grant_ch        = sel_ch;
    assign sdram_wraddr    = sel_ch ? ch1_wraddr    : ch0_wraddr;
    assign sdram_rdaddr    = sel_ch ? ch1_rdaddr    : ch0_rdaddr;
    assign sdram_wr_length = sel_ch ? ch1_wr_length : ch0_wr_length;
    assign sdram_rd_length = sel_ch ? ch1_rd_length : ch0_rd_length;
    assign sdram_din       = sel_ch ? ch1_din       : ch0_din;

    assign ch0_wr_ack = sdram_wr_ack & busy & ~dir_rd & ~sel_ch;
    assign ch1_wr_ack = sdram_wr_ack & busy & ~dir_rd &  sel_ch;
    assign ch0_rd_ack = sdram_rd_ack & busy &  dir_rd & ~sel_ch;
    assign ch1_rd_ack = sdram_rd_ack & busy &  dir_rd &  sel_ch;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    logic clk_ref = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_ref = ~clk_ref;

    logic        ch0_wr_req = 0, ch0_rd_req = 0, ch1_wr_req = 0, ch1_rd_req = 0;
    logic [21:0] wa [2];
    logic [21:0] ra [2];
    logic [8:0]  wl [2];
    logic [8:0]  rl [2];
    logic [15:0] dn [2];
    logic        sdram_wr_ack = 0, sdram_rd_ack = 0;

    logic        ch0_wr_ack, ch0_rd_ack, ch1_wr_ack, ch1_rd_ack;
    logic        sdram_wr_req, sdram_rd_req;
    logic [21:0] sdram_wraddr, sdram_rdaddr;
    logic [8:0]  sdram_wr_length, sdram_rd_length;
    logic [15:0] sdram_din;
    logic        grant_ch, busy, timeout_err;

    sdram_port_arbiter #(.ACK_TIMEOUT(255), .TO_W(8)) dut (
        .clk_ref(clk_ref), .rst_n(rst_n),
        .ch0_wr_req(ch0_wr_req), .ch0_rd_req(ch0_rd_req),
        .ch0_wraddr(wa[0]), .ch0_rdaddr(ra[0]),
        .ch0_wr_length(wl[0]), .ch0_rd_length(rl[0]), .ch0_din(dn[0]),
        .ch0_wr_ack(ch0_wr_ack), .ch0_rd_ack(ch0_rd_ack),
        .ch1_wr_req(ch1_wr_req), .ch1_rd_req(ch1_rd_req),
        .ch1_wraddr(wa[1]), .ch1_rdaddr(ra[1]),
        .ch1_wr_length(wl[1]), .ch1_rd_length(rl[1]), .ch1_din(dn[1]),
        .ch1_wr_ack(ch1_wr_ack), .ch1_rd_ack(ch1_rd_ack),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wraddr(sdram_wraddr), .sdram_rdaddr(sdram_rdaddr),
        .sdram_wr_length(sdram_wr_length), .sdram_rd_length(sdram_rd_length),
        .sdram_din(sdram_din),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .grant_ch(grant_ch), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        ch;
        logic        dir;   // 1 = read
        logic [21:0] addr;
        logic [8:0]  len;
        logic [15:0] din;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic m_last_wr = 1'b1;
    logic m_last_rd = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // The channel that did not go last wins when it is asking.
    function automatic logic pick(input logic last, input logic q0, input logic q1);
        if (last) return q0 ? 1'b0 : 1'b1;
        return q1 ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [3:0] steer_vec();
        return {ch1_rd_ack, ch0_rd_ack, ch1_wr_ack, ch0_wr_ack};
    endfunction

    task automatic set_reqs(input logic [3:0] r);
        {ch1_rd_req, ch0_rd_req, ch1_wr_req, ch0_wr_req} = r;
    endtask

    task automatic rand_data();
        for (int c = 0; c < 2; c++) begin
            wa[c] = 22'($urandom);
            ra[c] = 22'($urandom);
            wl[c] = 9'($urandom);
            rl[c] = 9'($urandom);
            dn[c] = 16'($urandom);
        end
    endtask

    // Model the grant for request pattern r = {ch1_rd, ch0_rd, ch1_wr, ch0_wr}.
    task automatic predict(input logic [3:0] r, output logic ch, output logic dir);
        exp_t e;
        if (r[1:0] != 2'b00) begin
            dir = 1'b0;
            ch  = pick(m_last_wr, r[0], r[1]);
        end else begin
            dir = 1'b1;
            ch  = pick(m_last_rd, r[2], r[3]);
        end
        e.ch   = ch;
        e.dir  = dir;
        e.addr = dir ? ra[ch] : wa[ch];
        e.len  = dir ? rl[ch] : wl[ch];
        e.din  = dn[ch];
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        do begin
            @(negedge clk_ref);
            #1;
            n++;
        end while (!(sdram_wr_req || sdram_rd_req) && n < 10);
        check("grant_seen", 32'(sdram_wr_req | sdram_rd_req), 1);
        ok = sdram_wr_req || sdram_rd_req;
    endtask

    task automatic do_burst(input logic [3:0] r, input bit withdraw);
        logic ch, dir;
        bit   ok;
        int   len;
        @(negedge clk_ref);
        predict(r, ch, dir);
        set_reqs(r);
        wait_grant(ok);
        if (!ok) begin
            set_reqs(4'b0000);
            void'(exp_q.pop_back());
            return;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk_ref);
        if (withdraw) begin
            set_reqs(4'b0000);
            @(negedge clk_ref);
            #1;
            check("withdraw_req", 32'(sdram_wr_req | sdram_rd_req), 0);
            check("withdraw_busy", 32'(busy), 0);
            check("withdraw_steer", 32'(steer_vec()), 0);
            return;
        end
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk_ref);
            if (dir) begin
                sdram_rd_ack = 1'b1;
                sdram_wr_ack = 1'($urandom_range(0, 1));
            end else begin
                sdram_wr_ack = 1'b1;
                sdram_rd_ack = 1'($urandom_range(0, 1));
            end
            if (i == 0) set_reqs(4'b0000);
            #1;
            check("ack_steer", 32'(steer_vec()), 32'(1 << (2 * int'(dir) + int'(ch))));
        end
        @(negedge clk_ref);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        #1;
        check("req_dropped", 32'(sdram_wr_req | sdram_rd_req), 0);
        check("steer_off", 32'(steer_vec()), 0);
        @(negedge clk_ref);
        #1;
        check("busy_release", 32'(busy), 1);
        @(negedge clk_ref);
        #1;
        check("busy_idle", 32'(busy), 0);
        if (dir) m_last_rd = ch;
        else     m_last_wr = ch;
    endtask

    // Monitor: each new core request must match the head of the scoreboard.
    initial begin
        logic prev = 1'b0;
        logic cur;
        exp_t e;
        forever begin
            @(negedge clk_ref);
            #1;
            cur = sdram_wr_req | sdram_rd_req;
            if (cur && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(cur), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_ch", 32'(grant_ch), 32'(e.ch));
                    check("grant_dir", 32'({sdram_rd_req, sdram_wr_req}), e.dir ? 32'd2 : 32'd1);
                    check("grant_addr", 32'(e.dir ? sdram_rdaddr : sdram_wraddr), 32'(e.addr));
                    check("grant_len", 32'(e.dir ? sdram_rd_length : sdram_wr_length), 32'(e.len));
                    if (!e.dir) check("grant_din", 32'(sdram_din), 32'(e.din));
                end
            end
            prev = cur;
        end
    end

    initial begin
        logic ch, dir;
        bit   ok;
        int   n;
        rand_data();
        repeat (2) @(negedge clk_ref);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_ch), 0);
        check("rst_reqs", 32'({sdram_wr_req, sdram_rd_req}), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        @(negedge clk_ref);
        rst_n = 1'b1;

        // Stray acks while idle are not steered and do not start anything.
        @(negedge clk_ref);
        sdram_wr_ack = 1'b1;
        sdram_rd_ack = 1'b1;
        #1;
        check("idle_ack_steer", 32'(steer_vec()), 0);
        @(negedge clk_ref);
        #1;
        check("idle_ack_busy", 32'(busy), 0);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;

        for (int i = 0; i < 4; i++) do_burst(4'b0011, 1'b0);
        do_burst(4'b0101, 1'b0);
        do_burst(4'b0100, 1'b0);
        do_burst(4'b1000, 1'b1);
        do_burst(4'b1100, 1'b0);

        for (int i = 0; i < 60; i++) begin
            @(negedge clk_ref);
            rand_data();
            do_burst(4'($urandom_range(1, 15)), $urandom_range(0, 7) == 0);
        end

        check("timeout_clear", 32'(timeout_err), 0);

        // Core never acks: request must stay up exactly 255 cycles.
        @(negedge clk_ref);
        begin : timeout_blk
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            predict(r, ch, dir);
            set_reqs(r);
            wait_grant(ok);
            n = 0;
            while ((sdram_wr_req || sdram_rd_req) && n < 300) begin
                n++;
                @(negedge clk_ref);
                #1;
            end
            set_reqs(4'b0000);
            check("timeout_len", 32'(n), 255);
            check("timeout_err", 32'(timeout_err), 1);
            check("timeout_idle", 32'(busy), 0);
            if (dir) m_last_rd = ch;
            else     m_last_wr = ch;
        end
        do_burst(4'b0011, 1'b0);
        do_burst(4'b1100, 1'b0);

        // Reset in the middle of a ch1 read burst.
        @(negedge clk_ref);
        ra[1] = 22'h12345;
        predict(4'b1000, ch, dir);
        set_reqs(4'b1000);
        wait_grant(ok);
        @(negedge clk_ref);
        sdram_rd_ack = 1'b1;
        set_reqs(4'b0000);
        repeat (3) @(negedge clk_ref);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'({sdram_wr_req, sdram_rd_req}), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant", 32'(grant_ch), 0);
        check("mid_rst_steer", 32'(steer_vec()), 0);
        check("mid_rst_timeout", 32'(timeout_err), 0);
        @(negedge clk_ref);
        sdram_rd_ack = 1'b0;
        rst_n = 1'b1;
        m_last_wr = 1'b1;
        m_last_rd = 1'b1;
        do_burst(4'b0011, 1'b0);
        do_burst(4'b1100, 1'b0);

        repeat (5) @(negedge clk_ref);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
